// File: rtl/uart_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
package uart_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
  localparam int unsigned DEFAULT_BAUD_DIV = 868;

  typedef enum logic [2:0] {
    LD_SYNC,
    LD_CNT_LO,
    LD_CNT_HI,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_loader_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling timer, LSB-first shifter.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  rx_state_e   state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        fall;
  logic        tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
    end
    shift_q <= shift_d;
  end

  // The start bit is checked half a bit in; every later sample is one full bit apart.
  always_comb begin
    fall = rx_prev_q & ~rx_s2_q;
    tick = (state_q == RX_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (tick) state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (tick || state_q == RX_IDLE) ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == RX_START) begin
      bit_d = '0;
    end
    if (state_q == RX_DATA && tick) begin
      shift_d = {rx_s2_q, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
  end

  always_comb begin
    rx_byte    = shift_q;
    byte_valid = (state_q == RX_STOP) && tick && rx_s2_q;
    frame_err  = (state_q == RX_STOP) && tick && !rx_s2_q;
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: consumes a framed image from the UART, writes words to instruction
// memory and releases the core from reset once the checksum verifies.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;

  ld_state_e   state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] cnt_rx;
  logic        sync_hit;
  logic        last_byte_of_word;

  uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_SYNC;
      cnt_lo_q   <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wd_q       <= '0;
      addr_q     <= BASE_ADDR;
      we_q       <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wd_q       <= wd_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      csum_q     <= csum_d;
    end
  end

  always_comb begin
    cnt_rx            = {rx_byte, cnt_lo_q};
    sync_hit          = byte_valid && (rx_byte == SYNC_BYTE);
    last_byte_of_word = byte_valid && (byte_idx_q == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_SYNC: if (sync_hit) state_d = LD_CNT_LO;
      LD_CNT_LO: begin
        if (frame_err)       state_d = LD_ERR;
        else if (byte_valid) state_d = LD_CNT_HI;
      end
      LD_CNT_HI: begin
        if (frame_err) state_d = LD_ERR;
        else if (byte_valid) begin
          if ({16'd0, cnt_rx} > 32'(MAX_WORDS)) state_d = LD_ERR;
          else if (cnt_rx == 16'd0)             state_d = LD_CSUM;
          else                                  state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (frame_err) state_d = LD_ERR;
        else if (last_byte_of_word && word_idx_q == n_q - 16'd1) state_d = LD_CSUM;
      end
      LD_CSUM: begin
        if (frame_err)       state_d = LD_ERR;
        else if (byte_valid) state_d = (rx_byte == csum_q) ? LD_DONE : LD_ERR;
      end
      default: state_d = state_q;
    endcase
  end

  // Address advances the cycle after the strobe so it stays stable while mem_we is high.
  always_comb begin
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wd_d       = wd_q;
    addr_d     = we_q ? addr_q + 32'd4 : addr_q;
    we_d       = 1'b0;
    csum_d     = csum_q;
    case (state_q)
      LD_SYNC: begin
        if (sync_hit) begin
          csum_d     = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          addr_d     = BASE_ADDR;
        end
      end
      LD_CNT_LO: if (byte_valid) cnt_lo_d = rx_byte;
      LD_CNT_HI: if (byte_valid) n_d = cnt_rx;
      LD_DATA: begin
        if (byte_valid) begin
          wd_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
          csum_d     = csum_q + rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            word_idx_d = word_idx_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_we   = we_q;
    mem_addr = addr_q;
    mem_wd   = wd_q;
    done     = (state_q == LD_DONE);
    error    = (state_q == LD_ERR);
    cpu_rst  = (state_q != LD_DONE);
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serialises frames onto rx and checks memory writes and status.
module tb_uart_loader;

  localparam int BAUD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  int          wr_cnt;
  int          we_long;
  logic        we_prev;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];

  logic [7:0] frm [$];
  logic [7:0] csum;

  uart_loader #(
    .BAUD_DIV (BAUD),
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(1024)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Write log; cleared while rst is high so each scenario starts from zero.
  always @(negedge clk) begin
    if (rst) begin
      wr_cnt  = 0;
      we_long = 0;
      we_prev = 1'b0;
    end else begin
      if (mem_we) begin
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] = mem_addr;
          wr_data[wr_cnt] = mem_wd;
        end
        wr_cnt = wr_cnt + 1;
        if (we_prev) we_long = we_long + 1;
      end
      we_prev = mem_we;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"},   {31'd0, mem_we},  32'd0);
    check_val({tag, "_addr"}, mem_addr,         32'd0);
    check_val({tag, "_wd"},   mem_wd,           32'd0);
    check_val({tag, "_crst"}, {31'd0, cpu_rst}, 32'd1);
    check_val({tag, "_done"}, {31'd0, done},    32'd0);
    check_val({tag, "_err"},  {31'd0, error},   32'd0);
  endtask

  initial begin
    do_reset();
    check_reset_outputs("rst0");

    // Two-word image, checksum = low byte of the data-byte sum (0x4C)
    frm  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    csum = 8'h00;
    for (int i = 3; i < frm.size(); i++) csum = csum + frm[i];
    check_val("csum_model", {24'd0, csum}, 32'h0000_004C);
    frm.push_back(csum);
    send_frm();
    check_val("ok_wrcnt", wr_cnt, 2);
    check_val("ok_addr0", wr_addr[0], 32'h0000_0000);
    check_val("ok_data0", wr_data[0], 32'h1234_5678);
    check_val("ok_addr1", wr_addr[1], 32'h0000_0004);
    check_val("ok_data1", wr_data[1], 32'hDEAD_BEEF);
    check_val("ok_done",  {31'd0, done},    32'd1);
    check_val("ok_crst",  {31'd0, cpu_rst}, 32'd0);
    check_val("ok_err",   {31'd0, error},   32'd0);
    check_val("ok_we1cy", we_long, 0);

    // Same image, wrong checksum
    do_reset();
    frm[frm.size() - 1] = 8'h4D;
    send_frm();
    check_val("bad_wrcnt", wr_cnt, 2);
    check_val("bad_data1", wr_data[1], 32'hDEAD_BEEF);
    check_val("bad_err",   {31'd0, error},   32'd1);
    check_val("bad_done",  {31'd0, done},    32'd0);
    check_val("bad_crst",  {31'd0, cpu_rst}, 32'd1);

    // Garbage bytes and a short low glitch ahead of an empty image
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (2 * BAUD) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frm();
    check_val("n0_wrcnt", wr_cnt, 0);
    check_val("n0_done",  {31'd0, done},    32'd1);
    check_val("n0_crst",  {31'd0, cpu_rst}, 32'd0);
    check_val("n0_err",   {31'd0, error},   32'd0);

    // Framing error on the third data byte
    do_reset();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
    foreach (frm[i]) send_byte(frm[i], 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (3) @(negedge clk);
    check_val("fe_err", {31'd0, error}, 32'd1);
    frm = '{8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    send_frm();
    check_val("fe_wrcnt", wr_cnt, 0);
    check_val("fe_done",  {31'd0, done}, 32'd0);
    check_val("fe_err2",  {31'd0, error}, 32'd1);

    // Word count 0x0401 exceeds MAX_WORDS
    do_reset();
    frm = '{8'hA5, 8'h01, 8'h04};
    send_frm();
    check_val("big_err", {31'd0, error}, 32'd1);
    frm = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frm();
    check_val("big_wrcnt", wr_cnt, 0);
    check_val("big_crst",  {31'd0, cpu_rst}, 32'd1);

    // Reset mid-frame, then a full one-word image (checksum 0xC5)
    do_reset();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    foreach (frm[i]) send_byte(frm[i], 1'b1);
    repeat (2) @(negedge clk);
    do_reset();
    check_reset_outputs("rst1");
    frm = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC5};
    send_frm();
    check_val("re_wrcnt", wr_cnt, 1);
    check_val("re_addr0", wr_addr[0], 32'h0000_0000);
    check_val("re_data0", wr_data[0], 32'hCAFE_F00D);
    check_val("re_done",  {31'd0, done},    32'd1);
    check_val("re_crst",  {31'd0, cpu_rst}, 32'd0);
    check_val("re_we1cy", we_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
